// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: types and constants shared by the alu request arbiter and the
// code that generates alu operations.
//   alu_ctrl_state_t : controller FSM states (IDLE -> EXEC -> RESP)
//   OP_*             : alu opcode encodings (ALU_Sel values). Every 4-bit code is
//                      legal; the arbiter passes them through untouched.
package alu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } alu_ctrl_state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_SHR  = 4'b0101;
  localparam logic [3:0] OP_ROL  = 4'b0110;
  localparam logic [3:0] OP_ROR  = 4'b0111;
  localparam logic [3:0] OP_AND  = 4'b1000;
  localparam logic [3:0] OP_OR   = 4'b1001;
  localparam logic [3:0] OP_XOR  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1011;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_XNOR = 4'b1101;
  localparam logic [3:0] OP_GT   = 4'b1110;
  localparam logic [3:0] OP_EQ   = 4'b1111;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req    in  N     request vector
//   ptr    in  ID_W  highest-priority index this cycle (must be < N)
//   gnt    out N     one-hot grant, zero when no request
//   gnt_id out ID_W  index of the granted requester (0 when none)
// Priority order is ptr, ptr+1, ... wrapping at N-1 -> 0.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic found;
  int   idx;

  // Walk priority slots k = 0..N-1; the inner loop keeps every bit select at a
  // constant index so nothing is indexed by a run-time value.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      for (int i = 0; i < N; i++) begin
        if (!found && (i == idx) && req[i]) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: shares one combinational alu among NUM_REQ requesters.
//   clk, rst_n                  clock / async active-low reset
//   req_valid/req_ready         per-requester handshake (req_ready one-hot)
//   req_a/req_b/req_sel         packed operands/opcode, requester i at slice i
//   alu_a/alu_b/alu_sel         registered drive to the alu
//   alu_out/alu_carry           alu results, captured at the end of EXEC
//   rsp_valid/rsp_ready         response handshake
//   rsp_id/rsp_out/rsp_carry    registered response payload
//   busy                        high while an op is in EXEC or RESP
// One op in flight: IDLE -> EXEC (alu evaluates) -> RESP (hold result until
// taken). A new grant may happen in the same cycle the response is taken, so
// back-to-back throughput is one op every two cycles.
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int WIDTH   = 8,
  parameter  int SEL_W   = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*SEL_W-1:0] req_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     rsp_carry,
  output logic                     busy
);

  logic [NUM_REQ-1:0][WIDTH-1:0] a_arr, b_arr;
  logic [NUM_REQ-1:0][SEL_W-1:0] sel_arr;

  assign a_arr   = req_a;
  assign b_arr   = req_b;
  assign sel_arr = req_sel;

  alu_ctrl_state_t  state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [SEL_W-1:0] op_sel_q, op_sel_d;
  logic [ID_W-1:0]  op_id_q, op_id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_out_q, rsp_out_d;
  logic             rsp_carry_q, rsp_carry_d;

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               can_grant;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_sel_d    = op_sel_q;
    op_id_d     = op_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_out_d   = rsp_out_q;
    rsp_carry_d = rsp_carry_q;
    can_grant   = 1'b0;

    case (state_q)
      ST_IDLE: can_grant = 1'b1;
      ST_EXEC: begin
        // alu inputs have been stable (from op regs) for this whole cycle.
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry;
        rsp_id_d    = op_id_q;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          can_grant   = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    req_ready = can_grant ? gnt : '0;
    // The arbiter grants whenever any request is valid.
    accept    = can_grant && (|req_valid);

    if (accept) begin
      op_a_d   = a_arr[gnt_id];
      op_b_d   = b_arr[gnt_id];
      op_sel_d = sel_arr[gnt_id];
      op_id_d  = gnt_id;
      ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      state_d  = ST_EXEC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_sel_q    <= '0;
      op_id_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_out_q   <= '0;
      rsp_carry_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_sel_q    <= op_sel_d;
      op_id_q     <= op_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_out_q   <= rsp_out_d;
      rsp_carry_q <= rsp_carry_d;
    end
  end

  // Op regs only change on accept, so the alu sees no toggling while idle.
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_sel   = op_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;

  localparam int N = 2;
  localparam int W = 8;
  localparam int S = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*W-1:0]   req_a, req_b;
  logic [N*S-1:0]   req_sel;
  logic [W-1:0]     alu_a, alu_b, alu_out;
  logic [S-1:0]     alu_sel;
  logic             alu_carry;
  logic             rsp_valid, rsp_ready, rsp_carry, busy;
  logic [0:0]       rsp_id;
  logic [W-1:0]     rsp_out;

  always #5 clk = ~clk;

  alu_req_arbiter #(.NUM_REQ(N), .WIDTH(W), .SEL_W(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .busy(busy)
  );

  // Behavioural alu: {carry, out}. Carry is the add carry for every opcode.
  function automatic logic [W:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [S-1:0] sel);
    logic [W:0]   t;
    logic [W-1:0] r;
    t = {1'b0, a} + {1'b0, b};
    case (sel)
      4'h0: r = a + b;
      4'h1: r = a - b;
      4'h2: r = W'(a * b);
      4'h3: r = (b == 0) ? '1 : a / b;
      4'h4: r = a << 1;
      4'h5: r = a >> 1;
      4'h6: r = {a[W-2:0], a[W-1]};
      4'h7: r = {a[0], a[W-1:1]};
      4'h8: r = a & b;
      4'h9: r = a | b;
      4'hA: r = a ^ b;
      4'hB: r = ~(a | b);
      4'hC: r = ~(a & b);
      4'hD: r = ~(a ^ b);
      4'hE: r = (a > b) ? W'(1) : W'(0);
      default: r = (a == b) ? W'(1) : W'(0);
    endcase
    return {t[W], r};
  endfunction

  assign {alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_sel);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  typedef struct {
    logic [0:0]   id;
    logic [W-1:0] out;
    logic         c;
  } exp_t;

  exp_t exp_q[$];
  int   grant_log[$];

  // Reference model: at most one op outstanding; response appears two cycles
  // after the handshake cycle and stays until taken; a new grant is possible
  // when nothing is outstanding or the response is taken this same cycle.
  int         cyc = 0;
  int         m_ptr = 0;
  bit         m_out = 0;
  int         m_acc = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  logic [S-1:0] m_sel = '0;

  always @(negedge clk) begin
    bit         exp_rv, hs, free, found;
    logic [N-1:0] exp_gnt;
    int         win, i;
    exp_t       e;
    if (!rst_n) begin
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_alu", {alu_a, alu_b, alu_sel}, 0);
      chk("rst_rsp", {rsp_id, rsp_out, rsp_carry}, 0);
      m_out = 0; m_ptr = 0; m_a = '0; m_b = '0; m_sel = '0;
      exp_q.delete();
    end else begin
      exp_rv = m_out && (cyc >= m_acc + 2);
      chk("rsp_valid", rsp_valid, exp_rv);
      chk("busy", busy, m_out);
      chk("alu_inputs", {alu_a, alu_b, alu_sel}, {m_a, m_b, m_sel});
      hs      = exp_rv && rsp_ready;
      free    = !m_out || hs;
      exp_gnt = '0;
      found   = 0;
      win     = 0;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          i = (m_ptr + k) % N;
          if (!found && req_valid[i]) begin
            found = 1; win = i; exp_gnt[i] = 1'b1;
          end
        end
      end
      chk("req_ready", req_ready, exp_gnt);
      if (hs) m_out = 0;
      if (found) begin
        m_a   = req_a[win*W +: W];
        m_b   = req_b[win*W +: W];
        m_sel = req_sel[win*S +: S];
        e.id  = 1'(win);
        {e.c, e.out} = alu_f(m_a, m_b, m_sel);
        exp_q.push_back(e);
        grant_log.push_back(win);
        m_out = 1; m_acc = cyc; m_ptr = (win + 1) % N;
      end
    end
    cyc++;
  end

  // Monitor: pops the scoreboard on every response handshake and checks the
  // response is held stable while backpressured.
  bit           hold_v = 0;
  logic [0:0]   h_id;
  logic [W-1:0] h_out;
  logic         h_c;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 0;
    end else begin
      if (hold_v)
        chk("rsp_hold_stable", {rsp_valid, rsp_id, rsp_out, rsp_carry}, {1'b1, h_id, h_out, h_c});
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL rsp_unexpected: got id %0d out %0h with no op outstanding", rsp_id, rsp_out);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_id", rsp_id, e.id);
          chk("rsp_out", rsp_out, e.out);
          chk("rsp_carry", rsp_carry, e.c);
        end
      end
      hold_v = rsp_valid && !rsp_ready;
      h_id = rsp_id; h_out = rsp_out; h_c = rsp_carry;
    end
  end

  task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [S-1:0] sel);
    req_a[id*W +: W]   = a;
    req_b[id*W +: W]   = b;
    req_sel[id*S +: S] = sel;
  endtask

  // Raise valid for one requester until it is granted, then drop it right
  // after the accepting edge.
  task automatic issue(input int id);
    bit ok = 0;
    req_valid[id] = 1'b1;
    for (int t = 0; t < 30; t++) begin
      @(negedge clk);
      if (req_ready[id]) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    if (!ok) begin
      n_total++;
      $display("FAIL issue_timeout: requester %0d not granted within 30 cycles", id);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_sel = '0; rsp_ready = 1'b1;
    step(3);
    rst_n = 1'b1;
    step(1);

    // 1: single op, response two cycles after the handshake cycle.
    set_req(0, 8'hF0, 8'h20, OP_ADD);
    issue(0);
    repeat (2) @(negedge clk);
    chk("t1_rsp_valid", rsp_valid, 1);
    chk("t1_rsp_id", rsp_id, 0);
    chk("t1_rsp_out", rsp_out, 8'h10);
    chk("t1_rsp_carry", rsp_carry, 1);
    step(3);

    // 2: contention from reset alternates 0,1,0,1.
    rst_n = 1'b0; step(1); rst_n = 1'b1;
    grant_log.delete();
    set_req(0, 8'h11, 8'h22, OP_XOR);
    set_req(1, 8'h80, 8'h90, OP_ADD);
    req_valid = 2'b11;
    step(8);
    req_valid = '0;
    step(3);
    chk("t2_num_grants", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4)
      for (int k = 0; k < 4; k++) chk("t2_grant_order", grant_log[k], k % 2);

    // 3: backpressure, then same-cycle regrant to requester 1.
    rsp_ready = 1'b0;
    set_req(0, 8'h3C, 8'h0F, OP_AND);
    issue(0);
    seen = 0;
    for (int t = 0; t < 10 && !seen; t++) begin
      @(negedge clk);
      seen = rsp_valid;
    end
    chk("t3_rsp_seen", seen, 1);
    @(posedge clk); #1;
    set_req(1, 8'hAA, 8'h55, OP_OR);
    req_valid[1] = 1'b1;
    step(5);
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("t3_same_cycle_grant", req_ready, 2'b10);
    @(posedge clk); #1;
    req_valid = '0;
    step(4);

    // 4: reset during EXEC discards the op; pointer returns to 0.
    set_req(0, 8'h01, 8'h02, OP_SUB);
    issue(0);
    chk("t4_busy_exec", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rsp_valid_in_rst", rsp_valid, 0);
    chk("t4_busy_in_rst", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(3);
    req_valid = 2'b11;
    @(negedge clk);
    chk("t4_first_grant", req_ready, 2'b01);
    @(posedge clk); #1;
    req_valid = '0;
    step(4);

    // 5: opcode sweep on requester 1.
    for (int s = 0; s < 16; s++) begin
      set_req(1, 8'h0C, 8'h05, 4'(s));
      issue(1);
      if (s == 0 || s == 11) begin
        repeat (2) @(negedge clk);
        chk("t5_rsp_out", rsp_out, (s == 0) ? 8'h11 : 8'hF2);
        chk("t5_rsp_carry", rsp_carry, 0);
        @(posedge clk); #1;
      end
    end
    step(4);

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++)
        set_req(i, 8'($urandom), 8'($urandom), 4'($urandom));
      req_valid = N'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      step(1);
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    step(6);
    chk("drain_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
